wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone slave port between m_count Wishbone masters.
- Sits in front of each crossbar slave port, or any shared peripheral, so that concurrent masters are serialised.
- Grants bus ownership for a whole cyc period, forwards the owner's strobe and data to the slave, and routes ack/rty back to the owner only.
- A watchdog aborts ownership with a retry when the slave does not respond.

Parameters:
m_count, 2, number of masters (>=2)
adr_width, 32, address width
dat_width, 32, data width
sel_width, dat_width/8, byte-select width
timeout, 255, max cycles an un-acked strobe may wait before abort; 0 disables the watchdog

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m_cyc  input  m_count  per-master cycle request
m_stb  input  m_count  per-master strobe
m_we  input  m_count  per-master write enable
m_adr  input  m_count*adr_width  packed addresses, master i at [i*adr_width +: adr_width]
m_datwr  input  m_count*dat_width  packed write data
m_sel  input  m_count*sel_width  packed byte selects
m_datrd  output  dat_width  read data, broadcast to all masters
m_ack  output  m_count  per-master ack
m_rty  output  m_count  per-master retry
s_cyc  output  1  slave cycle
s_stb  output  1  slave strobe
s_we  output  1  slave write enable
s_adr  output  adr_width  slave address
s_datwr  output  dat_width  slave write data
s_sel  output  sel_width  slave byte selects
s_datrd  input  dat_width  slave read data
s_ack  input  1  slave ack
s_rty  input  1  slave retry
grant  output  m_count  one-hot current owner; 0 when idle
busy  output  1  high in OWNED or ABORT

Behaviour:
- Reset (reset=0, asserted asynchronously):
  - state=IDLE; grant=0; busy=0; watchdog count=0; last=m_count-1, so master 0 has first priority.
  - All s_* outputs and all m_ack/m_rty are 0 while in reset.
- FSM states IDLE, OWNED, ABORT.
- IDLE:
  - s_cyc=s_stb=s_we=0; s_adr/s_datwr/s_sel=0; m_ack=m_rty=0.
  - If any m_cyc is high, select the first requester scanning last+1, last+2, ... modulo m_count.
  - On the next edge: register grant (one-hot), set last=winner, enter OWNED.
  - Grant latency is exactly 1 cycle from m_cyc high (in IDLE) to s_cyc high.
- OWNED, owner g (combinational mux):
  - s_cyc=m_cyc[g]; s_stb=m_stb[g]; s_we=m_we[g].
  - s_adr, s_datwr, s_sel taken from slice g.
  - m_ack[g]=s_ack & m_cyc[g] & m_stb[g]; m_rty[g]=s_rty & ~s_ack & m_cyc[g] & m_stb[g]. Ack wins if the slave asserts ack and rty together.
  - All non-owner m_ack/m_rty are 0.
  - m_datrd=s_datrd in every state.
- Release and hand-off:
  - When m_cyc[g]=0 in OWNED, the next state is IDLE and grant is cleared.
  - There is always at least one idle cycle (s_cyc=0) between consecutive owners.
  - Masters may hold cyc across multiple stb/ack beats; ownership is not revoked while cyc is high, except by the watchdog.
- Watchdog (timeout>0):
  - Counter width $clog2(timeout+1); it saturates and never wraps.
  - Increments each OWNED cycle with s_stb=1 and no s_ack/s_rty.
  - Clears on s_ack, s_rty, s_stb=0, or leaving OWNED.
  - When count==timeout-1 and a further wait cycle occurs, the next state is ABORT.
- ABORT (exactly 1 cycle):
  - s_cyc=s_stb=0; m_rty[g]=1; m_ack=0; grant holds g.
  - Next state is IDLE, with normal arbitration from there. A master still holding cyc competes again with lowest priority, because last=g.
- timeout=0: watchdog counter held at 0; ABORT is unreachable.
- Owner drops m_stb but keeps m_cyc: s_stb follows to 0; ownership is kept.
- Reset mid-transaction: all outputs go to their reset values immediately (asynchronously); no ack/rty is generated to the interrupted master.

Test Plan:
- Single requester: m_cyc[1]=m_stb[1]=1, adr=0x100, slave acks 2 cycles after s_stb -> s_cyc high 1 cycle after m_cyc; grant=2'b10; m_ack[1] pulses in the ack cycle; m_ack[0]=0.
- Contention: both masters raise cyc in the same cycle from reset -> master 0 owns first; after it drops cyc, 1 idle cycle, then grant=2'b10. Repeat both requesting -> master 0 wins again (rotation verified).
- Burst hold: master 0 holds cyc for 4 stb/ack beats while master 1 requests -> 4 acks to master 0; master 1 is granted only after master 0 drops cyc; s_adr follows master 0 beat by beat.
- Watchdog: timeout=4, slave never acks -> exactly 4 wait cycles in OWNED, then 1 ABORT cycle with m_rty[g]=1 and s_cyc=0; then IDLE.
- Simultaneous s_ack and s_rty -> m_ack[g]=1, m_rty[g]=0. Read data 0xDEADBEEF on s_datrd appears on m_datrd in the same cycle.
- Async reset mid-transfer: reset falls mid-cycle while OWNED -> s_cyc, grant and busy are 0 before the next clock edge; after release, master 0 has priority.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between m_count masters and one shared slave port.
// The arbiter takes the slave modport; the surrounding fabric takes master.
interface wb_rr_arbiter_if #(
    parameter int m_count   = 2,
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int sel_width = dat_width / 8
);
    logic [m_count-1:0]           m_cyc;
    logic [m_count-1:0]           m_stb;
    logic [m_count-1:0]           m_we;
    logic [m_count*adr_width-1:0] m_adr;
    logic [m_count*dat_width-1:0] m_datwr;
    logic [m_count*sel_width-1:0] m_sel;
    logic [dat_width-1:0]         m_datrd;
    logic [m_count-1:0]           m_ack;
    logic [m_count-1:0]           m_rty;

    logic                 s_cyc;
    logic                 s_stb;
    logic                 s_we;
    logic [adr_width-1:0] s_adr;
    logic [dat_width-1:0] s_datwr;
    logic [sel_width-1:0] s_sel;
    logic [dat_width-1:0] s_datrd;
    logic                 s_ack;
    logic                 s_rty;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_datwr, m_sel,
        output m_datrd, m_ack, m_rty,
        output s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel,
        input  s_datrd, s_ack, s_rty
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_datwr, m_sel,
        input  m_datrd, m_ack, m_rty,
        input  s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel,
        output s_datrd, s_ack, s_rty
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one owner per cyc period, with a
// watchdog that aborts a stalled strobe by retrying the owner.
module wb_rr_arbiter #(
    parameter int m_count   = 2,
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int sel_width = dat_width / 8,
    parameter int timeout   = 255
) (
    input  logic               clock,
    input  logic               reset,
    wb_rr_arbiter_if.slave     bus,
    output logic [m_count-1:0] grant,
    output logic               busy
);
    localparam int iw = $clog2(m_count);
    localparam int ww = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [ww-1:0] wd_last = ww'((timeout > 0) ? timeout - 1 : 0);
    localparam logic [ww-1:0] wd_max  = '1;
    localparam logic [iw-1:0] last_init = iw'(m_count - 1);
    localparam bit wd_on = (timeout > 0);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        ABORT
    } state_e;

    state_e             state_q, state_d;
    logic [m_count-1:0] grant_q, grant_d;
    logic [iw-1:0]      last_q, last_d;
    logic [ww-1:0]      wd_q, wd_d;

    logic [iw-1:0] win_idx;
    logic          win_found;
    logic          wait_cyc;
    logic          own_cyc;
    logic          own_stb;

    // last_q doubles as the owner index while OWNED or ABORT.
    assign own_cyc = bus.m_cyc[last_q];
    assign own_stb = bus.m_stb[last_q];

    always_comb begin
        int            j;
        logic [iw-1:0] idx;
        j         = 0;
        idx       = '0;
        win_idx   = last_q;
        win_found = 1'b0;
        for (int k = 1; k <= m_count; k++) begin
            j = int'(last_q) + k;
            if (j >= m_count) begin
                j = j - m_count;
            end
            idx = iw'(j);
            if (!win_found && bus.m_cyc[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = '0;
        bus.s_datwr = '0;
        bus.s_sel   = '0;
        bus.m_ack   = '0;
        bus.m_rty   = '0;
        unique case (state_q)
            OWNED: begin
                bus.s_cyc   = own_cyc;
                bus.s_stb   = own_stb;
                bus.s_we    = bus.m_we[last_q];
                bus.s_adr   = bus.m_adr[int'(last_q)*adr_width +: adr_width];
                bus.s_datwr = bus.m_datwr[int'(last_q)*dat_width +: dat_width];
                bus.s_sel   = bus.m_sel[int'(last_q)*sel_width +: sel_width];
                bus.m_ack[last_q] = bus.s_ack & own_cyc & own_stb;
                bus.m_rty[last_q] = bus.s_rty & ~bus.s_ack & own_cyc & own_stb;
            end
            ABORT: begin
                bus.m_rty[last_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.m_datrd = bus.s_datrd;

    assign wait_cyc = (state_q == OWNED) && bus.s_stb
                      && !bus.s_ack && !bus.s_rty;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = OWNED;
                    grant_d = m_count'(1) << win_idx;
                    last_d  = win_idx;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (wd_on && wait_cyc) begin
                    if (wd_q == wd_last) begin
                        state_d = ABORT;
                    end else if (wd_q != wd_max) begin
                        wd_d = wd_q + 1'b1;
                    end else begin
                        wd_d = wd_q;
                    end
                end
            end
            ABORT: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= last_init;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);
endmodule
